// File: rtl/fp32_pkg.sv
// Shared float32 constants and FSM state encoding for the BDPU square / sqrt units.
package fp32_pkg;
    localparam int FP32_BIAS   = 127;
    localparam int FP32_MANT_W = 23;
    localparam int FP32_EXP_W  = 8;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

    localparam int MUL_STEPS = FP32_MANT_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/mul24_serial.sv
// Serial shift-add 24x24 multiplier: one partial product per step, 48-bit accumulator.
module mul24_serial
    import fp32_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [23:0] mcand_i,
    output logic [47:0] prod_o,
    output logic        done_o
);
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        bit_sel;
    logic [47:0] pp;

    // Squaring: the multiplier and multiplicand are the same significand.
    always_comb begin
        bit_sel = |(mcand_i & (24'd1 << cnt_q));
        pp      = {24'd0, mcand_i} << cnt_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (start_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (step_i) begin
            if (bit_sel) acc_d = acc_q + pp;
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign prod_o = acc_q;
    assign done_o = step_i && (cnt_q == 5'(MUL_STEPS - 1));
endmodule

// File: rtl/square_f32.sv
// Iterative float32 squarer with EN/rdy enable-hold handshake; fixed 26-cycle latency.
//
// Handshake: EN is raised to start and must stay high through the operation and
// while the result is read; rdy/sq are valid only while rdy=1. Dropping EN at any
// edge aborts back to IDLE, and EN must be sampled low once before a new start.
module square_f32
    import fp32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [WIDTH-1:0] a,
    output logic             rdy,
    output logic [WIDTH-1:0] sq,
    output logic [1:0]       dbg_state_o
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] sq_q, sq_d;

    logic             start_mul, step_mul, mul_done;
    logic [47:0]      prod;

    logic [FP32_EXP_W-1:0]  e_a;
    logic [FP32_MANT_W-1:0] f_a;
    logic                   sign_sq;
    logic [9:0]             ex_base, ex_n, ex_f;
    logic [22:0]            mant;
    logic                   guard, sticky, rnd;
    logic [23:0]            mant_r;
    logic [31:0]            res;

    assign e_a     = a_q[30:23];
    assign f_a     = a_q[22:0];
    // Sign of a*a is s^s, which is always 0.
    assign sign_sq = a_q[31] ^ a_q[31];

    mul24_serial u_mul (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (start_mul),
        .step_i  (step_mul),
        .mcand_i ({|e_a, f_a}),
        .prod_o  (prod),
        .done_o  (mul_done)
    );

    always_comb begin
        ex_base = {1'b0, e_a, 1'b0} - 10'(FP32_BIAS);
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            ex_n   = ex_base + 10'd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            ex_n   = ex_base;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {23'd0, rnd};
        ex_f   = ex_n + {9'd0, mant_r[23]};

        if (e_a == '1)                     res = (f_a != '0) ? FP32_QNAN : FP32_PINF;
        else if (e_a == '0)                res = '0;
        else if ($signed(ex_f) >= 10'sd255) res = FP32_PINF;
        else if ($signed(ex_f) <= 10'sd0)   res = '0;
        else                               res = {sign_sq, ex_f[7:0], mant_r[22:0]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        rdy_d     = 1'b0;
        sq_d      = '0;
        start_mul = 1'b0;
        step_mul  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d   = ST_MUL;
                    a_d       = a;
                    start_mul = 1'b1;
                end
            end
            ST_MUL: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                end else begin
                    step_mul = 1'b1;
                    if (mul_done) state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    rdy_d   = 1'b1;
                    sq_d    = res;
                end
            end
            ST_DONE: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                end else begin
                    rdy_d = 1'b1;
                    sq_d  = sq_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            rdy_q   <= 1'b0;
            sq_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            rdy_q   <= rdy_d;
            sq_q    <= sq_d;
        end
    end

    assign rdy         = rdy_q;
    assign sq          = sq_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_square_f32.sv
// Directed bench for square_f32: float32 reference model, per-cycle output compare, literal checks.
module tb_square_f32;
    logic        clk;
    logic        rst;
    logic        EN;
    logic [31:0] a;
    logic        rdy;
    logic [31:0] sq;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected outputs, updated by the reference model at every rising edge.
    logic        exp_rdy = 1'b0;
    logic [31:0] exp_sq  = '0;
    logic        busy    = 1'b0;
    int          age     = 0;
    logic [31:0] op_lat  = '0;

    square_f32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .EN          (EN),
        .a           (a),
        .rdy         (rdy),
        .sq          (sq),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_sq(input logic [31:0] x);
        int e, m, sh, be;
        longint unsigned sig, p, kept, rem, half;
        e = int'(x[30:23]);
        if (e == 255) return (x[22:0] != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (e == 0) return 32'h0;
        sig = {40'd0, 1'b1, x[22:0]};
        p = sig * sig;
        m = 63;
        while (m > 0 && p[m] == 1'b0) m--;
        sh   = m - 23;
        kept = p >> sh;
        half = 64'd1 << (sh - 1);
        rem  = p & ((64'd1 << sh) - 64'd1);
        if (rem > half || (rem == half && kept[0])) kept++;
        if (kept == (64'd1 << 24)) begin
            kept = kept >> 1;
            m++;
        end
        be = 2 * (e - 127) + (m - 46) + 127;
        if (be >= 255) return 32'h7F80_0000;
        if (be <= 0) return 32'h0;
        return {1'b0, be[7:0], kept[22:0]};
    endfunction

    always @(posedge clk) begin
        if (!rst || !EN) begin
            busy    = 1'b0;
            age     = 0;
            exp_rdy = 1'b0;
            exp_sq  = '0;
        end else if (!busy) begin
            busy    = 1'b1;
            age     = 0;
            op_lat  = a;
            exp_rdy = 1'b0;
            exp_sq  = '0;
        end else begin
            age++;
            if (age >= 25) begin
                exp_rdy = 1'b1;
                exp_sq  = model_sq(op_lat);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_rdy", {31'd0, rdy}, {31'd0, exp_rdy});
        check("cyc_sq", sq, exp_sq);
    end

    // ---------------- drivers ----------------
    task automatic run_op(input logic [31:0] op, input logic [31:0] want, input string nm,
                          input bit scramble);
        int n;
        n = 0;
        @(negedge clk);
        a  = op;
        EN = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (scramble && n < 24) a = $urandom;
        end while (!rdy && n < 40);
        check({nm, "_lat"}, 32'(n), 32'd26);
        check(nm, sq, want);
        repeat (3) @(negedge clk);
        check({nm, "_hold"}, sq, want);
        EN = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rdy(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy && n < 40);
        check(nm, 32'(n), 32'd26);
    endtask

    logic [31:0] vec_in  [10];
    logic [31:0] vec_exp [10];

    initial begin
        vec_in[0] = 32'h4040_0000; vec_exp[0] = 32'h4110_0000;
        vec_in[1] = 32'hC000_0000; vec_exp[1] = 32'h4080_0000;
        vec_in[2] = 32'h3FC0_0000; vec_exp[2] = 32'h4010_0000;
        vec_in[3] = 32'h3F80_0001; vec_exp[3] = 32'h3F80_0002;
        vec_in[4] = 32'h7F00_0000; vec_exp[4] = 32'h7F80_0000;
        vec_in[5] = 32'h1F80_0000; vec_exp[5] = 32'h0000_0000;
        vec_in[6] = 32'h7FC0_0001; vec_exp[6] = 32'h7FC0_0000;
        vec_in[7] = 32'h0000_0001; vec_exp[7] = 32'h0000_0000;
        vec_in[8] = 32'hFF80_0000; vec_exp[8] = 32'h7F80_0000;
        vec_in[9] = 32'h3FFF_FFFF; vec_exp[9] = 32'h407F_FFFE;

        rst = 1'b0;
        EN  = 1'b0;
        a   = '0;
        #2;
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        check("reset_sq", sq, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vec_in[i], vec_exp[i], $sformatf("vec%0d", i), 1'b0);

        // operand changes during MUL must not matter
        run_op(32'h4040_0000, 32'h4110_0000, "scramble", 1'b1);

        // abort in cycle 10, then restart with full latency
        @(negedge clk);
        a  = 32'h3FC0_0000;
        EN = 1'b1;
        repeat (10) @(negedge clk);
        EN = 1'b0;
        @(negedge clk);
        check("abort_rdy", {31'd0, rdy}, 32'd0);
        run_op(32'h3FC0_0000, 32'h4010_0000, "restart", 1'b0);

        // EN falling on the NORM edge: rdy must never rise
        @(negedge clk);
        a  = 32'h4040_0000;
        EN = 1'b1;
        repeat (25) @(negedge clk);
        EN = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("norm_abort_rdy", {31'd0, rdy}, 32'd0);
        end

        // async reset mid-MUL
        @(negedge clk);
        a  = 32'hC000_0000;
        EN = 1'b1;
        repeat (12) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_mul_rdy", {31'd0, rdy}, 32'd0);
        check("rst_mul_sq", sq, 32'd0);
        EN = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        run_op(32'hC000_0000, 32'h4080_0000, "post_rst", 1'b0);

        // async reset while result is held; EN high across release starts a new op
        @(negedge clk);
        a  = 32'h4040_0000;
        EN = 1'b1;
        wait_rdy("done_lat");
        check("done_sq", sq, 32'h4110_0000);
        #2 rst = 1'b0;
        #1 check("rst_done_rdy", {31'd0, rdy}, 32'd0);
        check("rst_done_sq", sq, 32'd0);
        @(negedge clk);
        a = 32'h3F80_0001;
        #2 rst = 1'b1;
        wait_rdy("rst_release_lat");
        check("rst_release_sq", sq, 32'h3F80_0002);
        EN = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/square_f32.md
# square_f32

Iterative IEEE-754 single-precision squarer: computes `a*a` and is the inverse companion of the BDPU float32 square-root unit. It uses the same EN/rdy enable-hold handshake, so an operand can be round-tripped (`sqrt` → `square` or back) by the same controller logic. Mantissa multiplication is serial shift-add, one partial product per cycle, trading latency for area. Latency is fixed for every input.

## Interface
- `WIDTH`, 32, operand/result width; 32 is the only supported value.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `EN`  in  1  enable; must be held high for the whole operation and while the result is read.
- `a`  in  WIDTH  float32 operand; sampled only on the start edge.
- `rdy`  out  1  result valid; registered.
- `sq`  out  WIDTH  float32 result; registered; 0 whenever `rdy`=0.

## Operation
- **States:** IDLE, MUL, NORM, DONE.
- **IDLE:**
  - Sampling `EN`=1 at an edge latches `a`, clears the 48-bit accumulator and the 5-bit step counter, and moves to MUL.
  - Holding `EN`=0 stays in IDLE.
- **MUL:** 24 cycles, counter 0..23.
  - On each cycle, if multiplier bit[counter] of the 24-bit significand is 1, add `significand << counter` to the accumulator.
  - The significand is the hidden bit plus the fraction.
- **NORM:** 1 cycle.
  - Exponent: `ex = 2*E - 127`, 10-bit signed.
  - If product bit47 is set, take fraction bits[46:24] and `ex+1`. Otherwise take bits[45:23].
  - Round to nearest, ties to even, using the guard bit plus a sticky OR of the lower bits.
  - A mantissa carry-out increments `ex`.
  - Result is packed into the `sq` register and the block moves to DONE.
- **DONE:** `rdy`=1 and `sq` is held while `EN`=1. `EN`=0 returns to IDLE with `rdy`=0 and `sq`=0 at that edge.
- **Abort:** `EN`=0 in any state returns to IDLE at the next edge and discards partial work.
- **New operation:** requires `EN` low for at least 1 sampled cycle.
- **Sign:** the result sign is always 0.
- **Special cases:** always resolved in NORM, so latency is unchanged.
  - Zero or denormal input (E=0): result +0; denormals are flushed.
  - Infinity: result `0x7F800000`.
  - NaN: result canonical quiet NaN `0x7FC00000`.
  - Final `ex >= 255`: result +inf.
  - Final `ex <= 0`: result +0, no denormal output.
- **Operand:** changes on `a` after the start edge have no effect.

## Timing
- **Reset (`rst`=0):** immediately forces IDLE; `rdy`=0, `sq`=0, accumulator=0, counter=0.
- **Latency:** with the start edge as edge 0, `rdy` rises after edge 25: 24 MUL edges (1–24) plus 1 NORM edge (25). The result is visible in cycle 26, fixed for all inputs.
- **Output validity:** `rdy` and `sq` change only on clock edges or on asynchronous reset. `sq` is never nonzero while `rdy`=0.
- **Reset deasserting with `EN`=1:** the first edge after release is the start edge.
- **`EN` falling on the same edge NORM completes:** abort wins; the block goes to IDLE and `rdy` never rises.

## Structure
- **Shared package `fp32_pkg`:**
  - Constants: `FP32_BIAS`=127, `FP32_QNAN`=`0x7FC00000`, `FP32_PINF`=`0x7F800000`, `FP32_MANT_W`=23, `FP32_EXP_W`=8.
  - The 2-bit state encoding.
  - Reused by the sqrt path.
- **Sub-module `mul24_serial`:** accumulator, counter and shift-add datapath, with a start/done interface. `square_f32` holds the FSM, unpack, normalize, round and special-case logic.

## Test plan
- **Basic:** `a=0x40400000` (3.0), `EN` held → `rdy` high in cycle 26, `sq=0x41100000` (9.0); `sq`=0 and `rdy`=0 in cycles 1–25.
- **Sign and fraction:** `a=0xC0000000` → `0x40800000`; `a=0x3FC00000` → `0x40100000` (normalize path).
- **Rounding:** `a=0x3F800001` → `0x3F800002`.
- **Specials:**
  - `0x7F000000` → `0x7F800000` (overflow).
  - `0x1F800000` → `0x00000000` (underflow).
  - `0x7FC00001` → `0x7FC00000`.
  - `0x00000001` → `0x00000000`.
- **Abort and reset:**
  - Drop `EN` in cycle 10 → `rdy`=0 next edge. Re-raising `EN` restarts with full 26-cycle latency.
  - Assert `rst` mid-MUL → outputs 0 asynchronously.
- **Operand hold:** change `a` during MUL; result matches the latched operand.
